// File: rtl/tlb_refill_walker_pkg.sv
// Shared encodings for the TLB-refill walker: MMU command and register codes,
// walker FSM state codes, and the address helper for the even/odd PTE pair.
// No ports; imported by tlb_refill_walker.
package tlb_refill_walker_pkg;

    // MMU command port encodings
    typedef logic [1:0] mmu_cmd_t;
    localparam mmu_cmd_t MMU_CMD_NONE             = 2'd0;
    localparam mmu_cmd_t MMU_CMD_WRITE_REG        = 2'd1;
    localparam mmu_cmd_t MMU_CMD_WRITE_TLB_RANDOM = 2'd2;

    // MMU register selects used with MMU_CMD_WRITE_REG
    typedef logic [2:0] mmu_reg_t;
    localparam mmu_reg_t MMU_REG_ENTRYHI  = 3'd0;
    localparam mmu_reg_t MMU_REG_ENTRYLO0 = 3'd1;
    localparam mmu_reg_t MMU_REG_ENTRYLO1 = 3'd2;
    localparam mmu_reg_t MMU_REG_PAGEMASK = 3'd3;
    localparam mmu_reg_t MMU_REG_RANDOM   = 3'd4;

    // Walker FSM states
    localparam logic [3:0] TRW_S_IDLE   = 4'd0;
    localparam logic [3:0] TRW_S_WR_HI  = 4'd1;
    localparam logic [3:0] TRW_S_LD0    = 4'd2;
    localparam logic [3:0] TRW_S_WR_LO0 = 4'd3;
    localparam logic [3:0] TRW_S_LD1    = 4'd4;
    localparam logic [3:0] TRW_S_WR_LO1 = 4'd5;
    localparam logic [3:0] TRW_S_WR_PM  = 4'd6;
    localparam logic [3:0] TRW_S_WR_RND = 4'd7;
    localparam logic [3:0] TRW_S_TLBWR  = 4'd8;
    localparam logic [3:0] TRW_S_DONE   = 4'd9;
    localparam logic [3:0] TRW_S_FAULT  = 4'd10;

    // One 8-byte PTE pair per even/odd 4 KiB page pair (VPN2 = va[31:13]).
    function automatic logic [31:0] pte_pair_addr(input logic [31:0] base,
                                                  input logic [18:0] vpn2);
        return base + {10'b0, vpn2, 3'b000};
    endfunction

endpackage

// File: rtl/tlb_random_counter.sv
// Free-running TLB Random-register counter, decrementing between Wired and ENTRY_COUNT-1.
// Latency: new value every cycle; reset value ENTRY_COUNT-1.
// Backpressure: none, never stalls. Ports: clk, res, wired (lower bound), rnd (current value).
module tlb_random_counter #(
    parameter int ENTRY_ADDR_WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        res,
    input  logic [31:0]                 wired,
    output logic [ENTRY_ADDR_WIDTH-1:0] rnd
);

    localparam logic [ENTRY_ADDR_WIDTH-1:0] RND_MAX = '1;
    localparam logic [ENTRY_ADDR_WIDTH-1:0] RND_ONE = {{(ENTRY_ADDR_WIDTH-1){1'b0}}, 1'b1};

    // Wrap once we reach the wired boundary; a Wired value at or above the top
    // entry therefore pins the counter at ENTRY_COUNT-1.
    logic wrap;
    assign wrap = ({{(32-ENTRY_ADDR_WIDTH){1'b0}}, rnd} <= wired) || (rnd == '0);

    always_ff @(posedge clk) begin
        if (res) begin
            rnd <= RND_MAX;
        end else if (wrap) begin
            rnd <= RND_MAX;
        end else begin
            rnd <= rnd - RND_ONE;
        end
    end

endmodule

// File: rtl/tlb_refill_walker.sv
// Hardware TLB refill: fetch the even/odd PTE pair, program EntryHi/Lo0/Lo1/PageMask/Random, WRITE_TLB_RANDOM.
// Latency: start->done 9 cycles (fault 5) with zero-wait memory, +1 cycle per mem_ready wait.
// Backpressure: holds mem_req/mem_addr until mem_ready; start ignored unless idle.
// Ports: start/missVAddr/asid/ptBase (request), wired (Random bound), busy/done/fault (status),
//        mem_req/mem_addr/mem_ready/mem_data (PTE read), mmu_cmd/mmu_reg/mmu_dataIn (MMU command).
module tlb_refill_walker
    import tlb_refill_walker_pkg::*;
#(
    parameter int ENTRY_ADDR_WIDTH = 4
) (
    input  logic        clk,
    input  logic        res,
    input  logic        start,
    input  logic [31:0] missVAddr,
    input  logic [7:0]  asid,
    input  logic [31:0] ptBase,
    input  logic [31:0] wired,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_data,
    output mmu_cmd_t    mmu_cmd,
    output mmu_reg_t    mmu_reg,
    output logic [31:0] mmu_dataIn
);

    logic [3:0]                  state;
    logic [18:0]                 vpn2;
    logic [7:0]                  asid_q;
    logic [31:0]                 pte_addr_q;
    logic [31:0]                 lo0;
    logic [31:0]                 lo1;
    logic [ENTRY_ADDR_WIDTH-1:0] rnd;

    // Page offset bits never reach the TLB.
    logic unused_offset;
    assign unused_offset = ^missVAddr[12:0];

    tlb_random_counter #(.ENTRY_ADDR_WIDTH(ENTRY_ADDR_WIDTH)) u_rnd (
        .clk   (clk),
        .res   (res),
        .wired (wired),
        .rnd   (rnd)
    );

    always_ff @(posedge clk) begin
        if (res) begin
            state      <= TRW_S_IDLE;
            vpn2       <= '0;
            asid_q     <= '0;
            pte_addr_q <= '0;
            lo0        <= '0;
            lo1        <= '0;
        end else begin
            case (state)
                TRW_S_IDLE: begin
                    if (start) begin
                        state      <= TRW_S_WR_HI;
                        vpn2       <= missVAddr[31:13];
                        asid_q     <= asid;
                        pte_addr_q <= pte_pair_addr(ptBase, missVAddr[31:13]);
                    end
                end
                TRW_S_WR_HI:  state <= TRW_S_LD0;
                TRW_S_LD0: begin
                    if (mem_ready) begin
                        lo0   <= mem_data;
                        state <= TRW_S_WR_LO0;
                    end
                end
                TRW_S_WR_LO0: state <= TRW_S_LD1;
                TRW_S_LD1: begin
                    if (mem_ready) begin
                        lo1 <= mem_data;
                        // Only a pair with both halves invalid is a fault; a single
                        // invalid half is still installed.
                        state <= (!lo0[1] && !mem_data[1]) ? TRW_S_FAULT : TRW_S_WR_LO1;
                    end
                end
                TRW_S_WR_LO1: state <= TRW_S_WR_PM;
                TRW_S_WR_PM:  state <= TRW_S_WR_RND;
                TRW_S_WR_RND: state <= TRW_S_TLBWR;
                TRW_S_TLBWR:  state <= TRW_S_DONE;
                TRW_S_DONE:   state <= TRW_S_IDLE;
                TRW_S_FAULT:  state <= TRW_S_IDLE;
                default:      state <= TRW_S_IDLE;
            endcase
        end
    end

    // Outputs are a pure function of state (plus the live Random counter).
    always_comb begin
        busy       = (state != TRW_S_IDLE);
        done       = (state == TRW_S_DONE);
        fault      = (state == TRW_S_FAULT);
        mem_req    = 1'b0;
        mem_addr   = '0;
        mmu_cmd    = MMU_CMD_NONE;
        mmu_reg    = MMU_REG_ENTRYHI;
        mmu_dataIn = '0;
        case (state)
            TRW_S_WR_HI: begin
                mmu_cmd    = MMU_CMD_WRITE_REG;
                mmu_reg    = MMU_REG_ENTRYHI;
                mmu_dataIn = {vpn2, 5'b0, asid_q};
            end
            TRW_S_LD0: begin
                mem_req  = 1'b1;
                mem_addr = pte_addr_q;
            end
            TRW_S_WR_LO0: begin
                mmu_cmd    = MMU_CMD_WRITE_REG;
                mmu_reg    = MMU_REG_ENTRYLO0;
                mmu_dataIn = lo0;
            end
            TRW_S_LD1: begin
                mem_req  = 1'b1;
                mem_addr = pte_addr_q + 32'd4;
            end
            TRW_S_WR_LO1: begin
                mmu_cmd    = MMU_CMD_WRITE_REG;
                mmu_reg    = MMU_REG_ENTRYLO1;
                mmu_dataIn = lo1;
            end
            TRW_S_WR_PM: begin
                mmu_cmd    = MMU_CMD_WRITE_REG;
                mmu_reg    = MMU_REG_PAGEMASK;
            end
            TRW_S_WR_RND: begin
                mmu_cmd    = MMU_CMD_WRITE_REG;
                mmu_reg    = MMU_REG_RANDOM;
                mmu_dataIn = {{(32-ENTRY_ADDR_WIDTH){1'b0}}, rnd};
            end
            TRW_S_TLBWR:  mmu_cmd = MMU_CMD_WRITE_TLB_RANDOM;
            default: ;
        endcase
    end

endmodule
